// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the 5-stage pipeline.
//
// Holds the program counter and fetches from a variable-latency instruction
// memory over a req/ready handshake. Applies branch redirects from EXE and
// freezes from the hazard unit, and presents PC (fetched address + 4) and
// Instruction to the IF/ID register. A NOP bubble (all zero) is presented
// whenever no instruction is available.
//
// Parameters:
//   RESET_PC        PC value loaded on reset
//
// Ports:
//   clk             pipeline clock, rising edge
//   rst             asynchronous reset, active low
//   freeze          hazard-unit stall; IF/ID holds this cycle
//   branch_taken    redirect request from EXE (highest priority)
//   branch_addr     redirect target
//   imem_req        fetch request to instruction memory
//   imem_addr       fetch address, stable while imem_req=1 and imem_ready=0
//   imem_ready      read data valid this cycle (may rise with imem_req)
//   imem_rdata      instruction word
//   fetch_valid     PC/Instruction carry a real instruction this cycle
//   PC              fetched address + 4 when valid, else 0
//   Instruction     fetched word when valid, else 0
//
// Optional build macro IF_STAGE_PERF_EN adds:
//   perf_fetch_cnt  cycles with fetch_valid=1 and freeze=0 (wrapping)
//   perf_stall_cnt  cycles with imem_req=1 and imem_ready=0 (wrapping)
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [31:0] PC,
`ifdef IF_STAGE_PERF_EN
    output logic [31:0] Instruction,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`else
    output logic [31:0] Instruction
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_reg, pc_nxt;
    logic [31:0] hold_instr, hold_nxt;
    logic [31:0] drain_addr, drain_nxt;

    logic        req_c;
    logic [31:0] addr_c;
    logic        valid_c;
    logic [31:0] pc_out_c;
    logic [31:0] instr_c;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the combinational block below uses
    // blocking assignments because it describes wires, not storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FETCH;
            pc_reg     <= RESET_PC;
            hold_instr <= '0;
            drain_addr <= '0;
        end else begin
            state      <= state_nxt;
            pc_reg     <= pc_nxt;
            hold_instr <= hold_nxt;
            drain_addr <= drain_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_reg;
        hold_nxt  = hold_instr;
        drain_nxt = drain_addr;
        req_c     = 1'b0;
        addr_c    = '0;
        valid_c   = 1'b0;
        pc_out_c  = '0;
        instr_c   = '0;

        unique case (state)
            FETCH: begin
                req_c  = 1'b1;
                addr_c = pc_reg;
                if (branch_taken) begin
                    pc_nxt = branch_addr;
                    // Request still in flight to the old PC: its response
                    // must be swallowed before the new fetch can go out.
                    if (!imem_ready) begin
                        drain_nxt = pc_reg;
                        state_nxt = DRAIN;
                    end
                end else if (imem_ready) begin
                    valid_c  = 1'b1;
                    pc_out_c = pc_reg + 32'd4;
                    instr_c  = imem_rdata;
                    if (freeze) begin
                        // Memory will not repeat the word, so park it.
                        hold_nxt  = imem_rdata;
                        state_nxt = HOLD;
                    end else begin
                        pc_nxt = pc_reg + 32'd4;
                    end
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    pc_nxt    = branch_addr;
                    state_nxt = FETCH;
                end else begin
                    valid_c  = 1'b1;
                    pc_out_c = pc_reg + 32'd4;
                    instr_c  = hold_instr;
                    if (!freeze) begin
                        pc_nxt    = pc_reg + 32'd4;
                        state_nxt = FETCH;
                    end
                end
            end

            DRAIN: begin
                // Keep the stale address on the bus until it completes so the
                // handshake never sees the address move under a pending req.
                req_c  = 1'b1;
                addr_c = drain_addr;
                if (branch_taken) begin
                    pc_nxt = branch_addr;
                end else if (imem_ready) begin
                    state_nxt = FETCH;
                end
            end

            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // Outputs are forced to zero while reset is held, independent of state.
    assign imem_req    = rst & req_c;
    assign imem_addr   = rst ? addr_c   : 32'd0;
    assign fetch_valid = rst & valid_c;
    assign PC          = rst ? pc_out_c : 32'd0;
    assign Instruction = rst ? instr_c  : 32'd0;

`ifdef IF_STAGE_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch_valid && !freeze)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (imem_req && !imem_ready)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- directed self-checking bench for if_stage.
//
// The instruction memory is either zero-wait (ready tied to req, data equal
// to address) or driven cycle by cycle from the scenario tasks. Inputs change
// 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Observed outputs are packed as {imem_req, fetch_valid, imem_addr, PC,
// Instruction} and compared against hand-computed vectors.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        fetch_valid;
    logic [31:0] PC;
    logic [31:0] Instruction;
`ifdef IF_STAGE_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    logic        zw;
    logic        ready_drv;
    logic [31:0] rdata_drv;

    int checks = 0;
    int errors = 0;

    assign imem_ready = zw ? imem_req  : ready_drv;
    assign imem_rdata = zw ? imem_addr : rdata_drv;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .fetch_valid  (fetch_valid),
        .PC           (PC),
`ifdef IF_STAGE_PERF_EN
        .Instruction  (Instruction),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`else
        .Instruction  (Instruction)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [97:0] snap();
        return {imem_req, fetch_valid, imem_addr, PC, Instruction};
    endfunction

    function automatic logic [97:0] vec(input logic req, input logic vld,
                                        input logic [31:0] a, input logic [31:0] p,
                                        input logic [31:0] ins);
        return {req, vld, a, p, ins};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        freeze = 1'b0;
        branch_taken = 1'b0;
        branch_addr = '0;
        zw = 1'b1;
        ready_drv = 1'b0;
        rdata_drv = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [97:0] obs;
        rst = 1'b0;
        freeze = 1'b0;
        branch_taken = 1'b0;
        branch_addr = '0;
        zw = 1'b1;
        ready_drv = 1'b0;
        rdata_drv = '0;
        @(negedge clk);
        obs = snap();
        checks++;
        if (obs !== 98'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want %h", obs, 98'd0);
        end
    endtask

    task automatic test_zero_wait();
        logic [97:0] obs, exp;
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = snap();
            exp = vec(1'b1, 1'b1, 32'(4*i), 32'(4*i+4), 32'(4*i));
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL zero_wait[%0d] got %h want %h", i, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_wait3();
        logic [97:0] obs, exp;
        do_reset();
        zw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ready_drv = (i == 3);
            rdata_drv = (i == 3) ? 32'h1234_5678 : 32'h0;
            @(negedge clk);
            obs = snap();
            exp = (i == 3) ? vec(1'b1, 1'b1, 32'h0, 32'h4, 32'h1234_5678)
                           : vec(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL wait3[%0d] got %h want %h", i, obs, exp);
            end
            step();
        end
        ready_drv = 1'b0;
        @(negedge clk);
        obs = snap();
        exp = vec(1'b1, 1'b0, 32'h4, 32'h0, 32'h0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL wait3_next got %h want %h", obs, exp);
        end
    endtask

    task automatic test_freeze();
        logic [97:0] obs, exp;
        do_reset();
        step();
        step();
        // now fetching addr 8
        zw = 1'b0;
        ready_drv = 1'b1;
        rdata_drv = 32'hDEAD_BEEF;
        freeze = 1'b1;
        @(negedge clk);
        obs = snap();
        exp = vec(1'b1, 1'b1, 32'h8, 32'hC, 32'hDEAD_BEEF);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL freeze_capture got %h want %h", obs, exp);
        end
        step();
        ready_drv = 1'b0;
        rdata_drv = 32'h0;
        @(negedge clk);
        obs = snap();
        exp = vec(1'b0, 1'b1, 32'h0, 32'hC, 32'hDEAD_BEEF);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL freeze_hold got %h want %h", obs, exp);
        end
        step();
        freeze = 1'b0;
        @(negedge clk);
        obs = snap();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL freeze_release got %h want %h", obs, exp);
        end
        step();
        @(negedge clk);
        obs = snap();
        exp = vec(1'b1, 1'b0, 32'hC, 32'h0, 32'h0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL freeze_refetch got %h want %h", obs, exp);
        end
    endtask

    task automatic test_branch_drain();
        logic [97:0] obs, exp;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        // now fetching 0x10 with a 3-wait memory
        zw = 1'b0;
        ready_drv = 1'b0;
        branch_taken = 1'b1;
        branch_addr = 32'h100;
        for (int i = 0; i < 4; i++) begin
            ready_drv = (i == 3);
            rdata_drv = (i == 3) ? 32'h0000_0BAD : 32'h0;
            @(negedge clk);
            obs = snap();
            exp = vec(1'b1, 1'b0, 32'h10, 32'h0, 32'h0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL drain[%0d] got %h want %h", i, obs, exp);
            end
            step();
            branch_taken = 1'b0;
        end
        ready_drv = 1'b0;
        @(negedge clk);
        obs = snap();
        exp = vec(1'b1, 1'b0, 32'h100, 32'h0, 32'h0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL drain_redirect got %h want %h", obs, exp);
        end
    endtask

    task automatic test_branch_in_hold();
        logic [97:0] obs, exp;
        do_reset();
        zw = 1'b0;
        ready_drv = 1'b1;
        rdata_drv = 32'h0000_CAFE;
        freeze = 1'b1;
        step();
        // HOLD: branch and freeze together
        ready_drv = 1'b0;
        branch_taken = 1'b1;
        branch_addr = 32'h200;
        @(negedge clk);
        obs = snap();
        exp = vec(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL hold_branch got %h want %h", obs, exp);
        end
        step();
        branch_taken = 1'b0;
        freeze = 1'b0;
        zw = 1'b1;
        @(negedge clk);
        obs = snap();
        exp = vec(1'b1, 1'b1, 32'h200, 32'h204, 32'h200);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL hold_branch_fetch got %h want %h", obs, exp);
        end
    endtask

    task automatic test_wrap();
        logic [97:0] obs, exp;
        do_reset();
        branch_taken = 1'b1;
        branch_addr = 32'hFFFF_FFFC;
        @(negedge clk);
        obs = snap();
        exp = vec(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL wrap_redirect got %h want %h", obs, exp);
        end
        step();
        branch_taken = 1'b0;
        @(negedge clk);
        obs = snap();
        exp = vec(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL wrap_top got %h want %h", obs, exp);
        end
        step();
        @(negedge clk);
        obs = snap();
        exp = vec(1'b1, 1'b1, 32'h0, 32'h4, 32'h0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL wrap_zero got %h want %h", obs, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [97:0] obs, exp;
        do_reset();
        step();
        step();
        zw = 1'b0;
        ready_drv = 1'b0;
        step();
        // request to 8 outstanding; assert reset asynchronously mid-cycle
        #2;
        rst = 1'b0;
        #1;
        obs = snap();
        checks++;
        if (obs !== 98'd0) begin
            errors++;
            $display("FAIL reset_mid got %h want %h", obs, 98'd0);
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        obs = snap();
        exp = vec(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_mid_refetch got %h want %h", obs, exp);
        end
`ifdef IF_STAGE_PERF_EN
        checks++;
        if (perf_fetch_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_fetch_cnt got %h want %h", perf_fetch_cnt, 32'd0);
        end
        checks++;
        if (perf_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_stall_cnt got %h want %h", perf_stall_cnt, 32'd0);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_wait3();
        test_freeze();
        test_branch_drain();
        test_branch_in_hold();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline register. Holds the program counter and fetches from a variable-latency instruction memory over a req/ready handshake. Applies branch redirects and pipeline freeze, and presents `PC` (address of next sequential instruction) and `Instruction` to the IF/ID register. When no instruction is available, the outputs carry a NOP bubble.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset; asserted when 0
- `freeze`  in  1  hazard-unit stall; IF/ID register holds this cycle
- `branch_taken`  in  1  redirect request from EXE stage
- `branch_addr`  in  32  redirect target
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1 until `imem_ready`
- `imem_ready`  in  1  read data valid this cycle; may rise in the same cycle as `imem_req`
- `imem_rdata`  in  32  instruction word
- `fetch_valid`  out  1  `PC`/`Instruction` hold a real instruction this cycle
- `PC`  out  32  fetched address + 4 when valid, else 0
- `Instruction`  out  32  fetched word when valid, else 0 (NOP)

## Operation
- Registers:
  - `pc_reg`: reset `RESET_PC`
  - `hold_instr`: reset 0
  - `state`: reset FETCH
- States and behaviour:
  - **FETCH**: `imem_req`=1, `imem_addr`=`pc_reg`.
    - On `imem_ready` with no branch, the instruction is valid this cycle (combinational pass-through).
    - If `freeze`=0: `pc_reg` <= `pc_reg`+4 and remain in FETCH.
    - If `freeze`=1: `hold_instr` <= `imem_rdata` and go to HOLD.
    - Without `imem_ready`: request held, outputs are a bubble.
  - **HOLD**: `imem_req`=0. Outputs are valid from `hold_instr` with `PC`=`pc_reg`+4. When `freeze`=0: `pc_reg` <= `pc_reg`+4, go to FETCH.
  - **DRAIN**: a request is outstanding to a stale address. `imem_req`=1 and `imem_addr`=`drain_addr` (captured at redirect). Outputs are a bubble. On `imem_ready` the data is discarded and the state goes to FETCH.
- `branch_taken` has highest priority, over `freeze` and `imem_ready`:
  - `pc_reg` <= `branch_addr` and outputs are a bubble this cycle.
  - In FETCH without `imem_ready`: `drain_addr` <= `pc_reg`, go to DRAIN.
  - In FETCH with `imem_ready`: data is dropped, stay in FETCH.
  - In HOLD: `hold_instr` is dropped, go to FETCH.
  - In DRAIN: `pc_reg` is updated and the state stays DRAIN.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- Handshake rule: `imem_addr` never changes while `imem_req`=1 and `imem_ready`=0.

## Timing
- While `rst`=0, all outputs are 0: `imem_req`=0, `imem_addr`=0, `fetch_valid`=0, `PC`=0, `Instruction`=0.
- First request is issued in the first cycle after reset release, at `RESET_PC`.
- Zero-wait memory (`imem_ready` tied to `imem_req`): one instruction per cycle, with a combinational `imem_rdata` -> `Instruction` path.
- N-wait memory: valid N cycles after the request rises.
- Redirect in cycle n:
  - With no outstanding stale request, `imem_addr`=`branch_addr` in cycle n+1.
  - In DRAIN, the new fetch is issued in the cycle after the stale `imem_ready`.
- Freeze deasserting in HOLD: the next fetch request is issued the following cycle. The held instruction stays valid through the release cycle.
- Reset asserted mid-request: the stage returns immediately to the reset state; the memory is required to tolerate a dropped request.

## Configuration
- `IF_STAGE_PERF_EN` defined adds two outputs, both 32-bit, both reset 0, both wrapping:
  - `perf_fetch_cnt`: counts cycles where `fetch_valid`=1 and `freeze`=0.
  - `perf_stall_cnt`: counts cycles where `imem_req`=1 and `imem_ready`=0.
- `IF_STAGE_PERF_EN` undefined: the ports and counters are absent and behaviour is otherwise identical.

## Test plan
- Reset release, zero-wait memory returning addr-as-data -> `imem_addr` 0, 4, 8 on consecutive cycles; `PC` 4, 8, 12; `fetch_valid`=1 every cycle.
- 3-wait memory -> `imem_addr` 0 stable for 4 cycles; `fetch_valid` high only in the 4th; next request at 4.
- `freeze`=1 for 2 cycles while `imem_ready` returns 32'hDEAD_BEEF at addr 8 -> HOLD; `Instruction`=32'hDEAD_BEEF and `PC`=12 held; `imem_req`=0; fetch of 12 issued after `freeze` drops.
- `branch_taken` with `branch_addr`=32'h100 while a 3-wait fetch of 0x10 is outstanding -> `imem_addr` stays 0x10 until ready; data discarded (`fetch_valid`=0); next `imem_addr`=0x100.
- `branch_taken` and `freeze` in the same cycle in HOLD -> held word dropped, `pc_reg`=`branch_addr`, FETCH next cycle.
- `rst` low during WAIT, then released -> outputs 0 during reset; first request to `RESET_PC`; with `IF_STAGE_PERF_EN` both counters read 0.
